// File: rtl/switch_arbiter.sv
// Round-robin arbiter/sequencer for the three-input switch: one owner at a time,
// bounded hold under contention, and a one-cycle dead gap between owners.
module switch_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       en,
    output logic       busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        r_state, w_state;
    logic [2:0]    r_gnt, w_gnt;
    logic [1:0]    r_sel, w_sel;
    logic          r_en, w_en;
    logic          r_busy, w_busy;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt;
    logic [1:0]    r_last, w_last;

    logic [1:0]    w_pick;
    logic          w_any_req;
    logic          w_owner_req;
    logic          w_contested;
    logic          w_at_max;

    // Rotating scan from (last+1) mod 3; descending loop lets the nearest index win.
    function automatic logic [1:0] arb_pick(input logic [2:0] r, input logic [1:0] last);
        int idx;
        arb_pick = 2'd3;
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (r[idx]) arb_pick = 2'(idx);
        end
    endfunction

    assign w_pick      = arb_pick(req, r_last);
    assign w_any_req   = |req;
    assign w_owner_req = |(req & r_gnt);
    assign w_contested = |(req & ~r_gnt);
    assign w_at_max    = (r_hold_cnt == HW'(MAX_HOLD));

    always_comb begin
        // NOTE: every next-value is defaulted to its current value first, so no path infers a latch.
        w_state    = r_state;
        w_gnt      = r_gnt;
        w_sel      = r_sel;
        w_en       = r_en;
        w_busy     = r_busy;
        w_hold_cnt = r_hold_cnt;
        w_last     = r_last;

        unique case (r_state)
            ST_IDLE, ST_RELEASE: begin
                if (w_any_req) begin
                    w_state    = ST_GRANT;
                    w_gnt      = 3'b001 << w_pick;
                    w_sel      = w_pick;
                    w_en       = 1'b1;
                    w_busy     = 1'b1;
                    w_hold_cnt = HW'(1);
                end else begin
                    w_state    = ST_IDLE;
                    w_gnt      = 3'b000;
                    w_sel      = 2'b11;
                    w_en       = 1'b0;
                    w_busy     = 1'b0;
                    w_hold_cnt = '0;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req || (w_at_max && w_contested)) begin
                    w_state = ST_RELEASE;
                    w_last  = r_sel;
                    w_gnt   = 3'b000;
                    w_sel   = 2'b11;
                    w_en    = 1'b0;
                    w_busy  = 1'b1;
                end else if (!w_at_max) begin
                    w_hold_cnt = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_state    = ST_IDLE;
                w_gnt      = 3'b000;
                w_sel      = 2'b11;
                w_en       = 1'b0;
                w_busy     = 1'b0;
                w_hold_cnt = '0;
            end
        endcase
    end

    // Async reset idles the outputs at once, so the switch never holds a stale source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 3'b000;
            r_sel      <= 2'b11;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
            r_last     <= 2'd2;
        end else begin
            // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
            r_state    <= w_state;
            r_gnt      <= w_gnt;
            r_sel      <= w_sel;
            r_en       <= w_en;
            r_busy     <= w_busy;
            r_hold_cnt <= w_hold_cnt;
            r_last     <= w_last;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign en   = r_en;
    assign busy = r_busy;

endmodule

// File: tb/tb_switch_arbiter.sv
// Self-checking bench for switch_arbiter: vector table, hand-written corner
// sequences, and randomized requests against an owner/dead-gap reference model.
module tb_switch_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int STARVE_BOUND = 2 * (MAX_HOLD + 1);

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       busy;

    int n_checks;
    int n_errors;

    switch_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .en   (en),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       en;
        logic       busy;
    } vec_t;

    vec_t tbl[18];

    // Reference model: who owns the switch, whether a dead gap is running,
    // how long the owner has held, and who owned last.
    int m_owner;
    int m_held;
    int m_last;
    bit m_dead;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] eg, input logic [1:0] es,
                                 input logic ee, input logic eb);
        check($sformatf("%s gnt", tag), 8'(gnt), 8'(eg));
        check($sformatf("%s sel", tag), 8'(sel), 8'(es));
        check($sformatf("%s en", tag), 8'(en), 8'(ee));
        check($sformatf("%s busy", tag), 8'(busy), 8'(eb));
    endtask

    task automatic check_invariants(input string tag);
        check($sformatf("%s onehot0", tag), 8'($onehot0(gnt)), 8'd1);
        check($sformatf("%s en==|gnt", tag), 8'(en), 8'(|gnt));
        check($sformatf("%s sel11 iff idle", tag), 8'(sel == 2'b11), 8'(gnt == 3'b000));
        if (gnt != 3'b000)
            check($sformatf("%s sel index", tag), 8'(gnt), 8'(3'b001 << sel));
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] g, input logic [1:0] s,
                                input logic e, input logic b);
        vec_t v;
        v.req = r; v.gnt = g; v.sel = s; v.en = e; v.busy = b;
        return v;
    endfunction

    function automatic int model_pick(input logic [2:0] r, input int lst);
        for (int k = 1; k <= 3; k++) begin
            if (r[(lst + k) % 3]) return (lst + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 2;
        m_dead  = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] r);
        int w;
        if (m_owner >= 0) begin
            if (!r[m_owner] || (m_held == MAX_HOLD && (r & ~(3'b001 << m_owner)) != 3'b000)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_dead  = 1'b1;
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end
        end else begin
            m_dead = 1'b0;
            w = model_pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [2:0] eg;
        logic [1:0] es;
        eg = 3'b000;
        es = 2'b11;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            es = 2'(m_owner);
        end
        check_outputs(tag, eg, es, m_owner >= 0, (m_owner >= 0) || m_dead);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 3'b000, 2'b11, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic step(input logic [2:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_cnt[3];
        bit armed[3];
        int max_wait;
        logic [2:0] r;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        req = 3'b000;

        // Full contention from reset: B1, dead, B2, dead, B3, dead, B1, then drop.
        for (int i = 0; i < 4; i++) tbl[i] = mk(3'b111, 3'b001, 2'b00, 1'b1, 1'b1);
        tbl[4] = mk(3'b111, 3'b000, 2'b11, 1'b0, 1'b1);
        for (int i = 5; i < 9; i++) tbl[i] = mk(3'b111, 3'b010, 2'b01, 1'b1, 1'b1);
        tbl[9] = mk(3'b111, 3'b000, 2'b11, 1'b0, 1'b1);
        for (int i = 10; i < 14; i++) tbl[i] = mk(3'b111, 3'b100, 2'b10, 1'b1, 1'b1);
        tbl[14] = mk(3'b111, 3'b000, 2'b11, 1'b0, 1'b1);
        tbl[15] = mk(3'b111, 3'b001, 2'b00, 1'b1, 1'b1);
        tbl[16] = mk(3'b000, 3'b000, 2'b11, 1'b0, 1'b1);
        tbl[17] = mk(3'b000, 3'b000, 2'b11, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].req);
            check_outputs($sformatf("rotate[%0d]", i), tbl[i].gnt, tbl[i].sel, tbl[i].en, tbl[i].busy);
        end

        // Sole requester keeps its grant with no dead cycle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(3'b001);
            check_outputs($sformatf("sole[%0d]", i), 3'b001, 2'b00, 1'b1, 1'b1);
        end

        // B2 owns, then all requests drop: one dead cycle, then idle.
        do_reset();
        step(3'b010);
        check_outputs("b2 own", 3'b010, 2'b01, 1'b1, 1'b1);
        step(3'b000);
        check_outputs("b2 drop", 3'b000, 2'b11, 1'b0, 1'b1);
        step(3'b000);
        check_outputs("b2 idle", 3'b000, 2'b11, 1'b0, 1'b0);

        // B1 at max hold drops exactly as B3 rises: single release, then B3.
        do_reset();
        for (int i = 0; i < MAX_HOLD; i++) step(3'b001);
        check_outputs("b1 at max", 3'b001, 2'b00, 1'b1, 1'b1);
        step(3'b100);
        check_outputs("b1 drop+pre", 3'b000, 2'b11, 1'b0, 1'b1);
        step(3'b100);
        check_outputs("b3 after rel", 3'b100, 2'b10, 1'b1, 1'b1);

        // Asynchronous reset mid-grant, then pointer restarts at B1 side.
        do_reset();
        step(3'b010);
        check_outputs("pre-rst b2", 3'b010, 2'b01, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_outputs("async rst", 3'b000, 2'b11, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(3'b110);
        check_outputs("post-rst grant", 3'b010, 2'b01, 1'b1, 1'b1);

        // Randomized requests against the reference model.
        do_reset();
        max_wait = 0;
        for (int i = 0; i < 3; i++) begin
            wait_cnt[i] = 0;
            armed[i] = 1'b0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 3; b++) r[b] = ($urandom_range(3) != 0);
            req = r;
            @(posedge clk);
            model_step(r);
            #1;
            check_model("rand");
            check_invariants("rand");
            for (int b = 0; b < 3; b++) begin
                if (gnt[b] || !r[b]) begin
                    wait_cnt[b] = 0;
                    armed[b] = 1'b0;
                end else begin
                    if (gnt != 3'b000) armed[b] = 1'b1;
                    if (armed[b]) wait_cnt[b]++;
                    if (wait_cnt[b] > max_wait) max_wait = wait_cnt[b];
                end
            end
        end
        check("starvation bound", 8'(max_wait <= STARVE_BOUND), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
